// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline-boundary register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating downstream-idle counter.
module pipe_stage_reg #(
  parameter int                DATA_W    = 192,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              in_fire, out_fire;

  // Handshake outputs come from registered state only, so in_ready never depends on out_ready.
  assign in_ready   = (state_q != TWO);
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = out_valid ? main_q : NOP_VALUE;
  assign occupancy  = state_q;
  assign bubble_cnt = bubble_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      main_q   <= NOP_VALUE;
      skid_q   <= NOP_VALUE;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      bubble_q <= bubble_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Anything accepted during the flush cycle is killed along with the held entries.
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (out_ready && !out_valid && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-boundary register for the MIPS pipeline. It is the generalised successor of the fixed ID/EX latch. It carries an arbitrary-width packed payload (IR, PC4, RS, RT, EXT, PC8, ...) with a valid/ready handshake and a two-entry skid buffer. Supports synchronous flush (bubble insertion) and counts downstream idle cycles for performance analysis. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 192, payload width in bits (default = six 32-bit fields).
NOP_VALUE, 0, payload value presented when empty or after flush (all-zero = nop instruction).
CNT_W, 16, width of the bubble counter.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clock clk
flush  input  1  synchronous kill of all held entries (branch/hazard bubble)
in_valid  input  1  upstream presents payload
in_ready  output  1  stage can accept payload this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  stage holds a valid payload
out_ready  input  1  downstream accepts payload this cycle
out_data  output  DATA_W  payload to downstream
occupancy  output  2  entries held: 0, 1 or 2
bubble_cnt  output  CNT_W  saturating count of downstream idle cycles

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) plus skid register. State = occupancy: EMPTY(0), ONE(1), TWO(2).
- in_ready = (occupancy != 2); driven from registered state only, no combinational path from out_ready.
- out_valid = (occupancy != 0).
- out_data = main when out_valid, else NOP_VALUE.
- Priority per cycle: reset > flush > normal transfer.
- Reset: occupancy 0; main, skid = NOP_VALUE; bubble_cnt 0. Resulting outputs: out_valid 0, in_ready 1, out_data NOP_VALUE.
- Flush (reset low):
  - Next cycle: occupancy 0; main, skid = NOP_VALUE.
  - An in_fire in the flush cycle is consumed but discarded. Upstream must treat that payload as killed.
  - bubble_cnt is not affected by flush.
- Transitions (no reset, no flush):
  - EMPTY: in_fire -> ONE, main <= in_data. Otherwise stay.
  - ONE: in_fire & out_fire -> ONE, main <= in_data.
  - ONE: in_fire & !out_fire -> TWO, skid <= in_data, main unchanged.
  - ONE: !in_fire & out_fire -> EMPTY, main <= NOP_VALUE.
  - ONE: neither -> hold.
  - TWO: in_ready = 0. out_fire -> ONE, main <= skid, skid <= NOP_VALUE. Otherwise hold.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid/out_data.
  - Sustains one transfer per cycle while out_ready is held high.
  - Order strictly FIFO; no payload dropped or duplicated except on flush.
- Stall semantics: out_ready low freezes main. Upstream stalls via in_ready only after the skid slot fills (one-cycle slack).
- bubble_cnt:
  - Increments by 1 on every cycle with out_ready = 1 and out_valid = 0.
  - Saturates at 2^CNT_W - 1, no wrap.
  - Cleared only by reset.
- Payload is opaque: no field decoding, no sign or width manipulation.
- Idle inputs: in_data is ignored when in_fire = 0. out_ready is ignored when out_valid = 0, except for counting.

Test Plan:
1. Reset check: assert reset 2 cycles -> out_valid 0, in_ready 1, occupancy 0, out_data 0, bubble_cnt 0.
2. Streaming: out_ready = 1, in_valid = 1, in_data = 1..8 on consecutive cycles -> out_data 1..8 each one cycle later; occupancy constant 1; in_ready never low.
3. Backpressure: out_ready = 0, push A, B -> occupancy 2, in_ready 0, C held by upstream. Then out_ready = 1 -> out_data A, B, C on consecutive cycles, in_ready returns to 1 the cycle after A leaves.
4. Flush while full, with in_valid = 1 and D present -> next cycle occupancy 0, out_valid 0, out_data 0, in_ready 1; D never appears on out_data.
5. Bubble counter: after reset, out_ready = 1, in_valid = 0 for 5 cycles -> bubble_cnt = 5. With CNT_W = 3, 10 idle cycles -> bubble_cnt = 7 (saturated). Flush leaves the count unchanged.
6. Simultaneous in_fire and out_fire at occupancy 1 (main = X, in_data = Y) -> occupancy stays 1, out_data = Y next cycle, X consumed exactly once.
